// File: rtl/mor1kx_store_buffer_pkg.sv
// Shared definitions for the store buffer: bus FSM state encoding and the
// layout of one queued store {adr, dat, bsel}.
package mor1kx_store_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    WR_BUS = 3'b010,
    RD_BUS = 3'b100
  } state_e;

  // Entry layout, LSB first: bsel, then dat, then adr.
  function automatic int bsel_width(input int ow);
    return ow / 8;
  endfunction

  function automatic int dat_lsb(input int ow);
    return bsel_width(ow);
  endfunction

  function automatic int adr_lsb(input int ow);
    return bsel_width(ow) + ow;
  endfunction

  function automatic int entry_width(input int ow);
    return 2 * ow + bsel_width(ow);
  endfunction

endpackage

// File: rtl/mor1kx_store_fifo.sv
// Synchronous FIFO for posted stores; one extra pointer bit tells full from
// empty when the read and write indices coincide.
module mor1kx_store_fifo #(
  parameter int DEPTH_WIDTH = 2,
  parameter int DATA_WIDTH  = 68
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_WIDTH:0]  count
);

  localparam logic [DEPTH_WIDTH:0] PTR_ONE = 1;

  logic [DEPTH_WIDTH:0]  wr_ptr;
  logic [DEPTH_WIDTH:0]  rd_ptr;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[DEPTH_WIDTH-1:0]] <= din;
  end

  assign head  = mem[rd_ptr[DEPTH_WIDTH-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_WIDTH] != rd_ptr[DEPTH_WIDTH]) &&
                 (wr_ptr[DEPTH_WIDTH-1:0] == rd_ptr[DEPTH_WIDTH-1:0]);

endmodule

// File: rtl/mor1kx_store_buffer.sv
// Write-posting buffer between the data cache and the bus bridge: stores are
// acked on enqueue and drained in order; reads pass through once it is empty.
module mor1kx_store_buffer
  import mor1kx_store_buffer_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int DEPTH_WIDTH          = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              up_req_i,
  input  logic                              up_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   up_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   up_dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] up_bsel_i,
  output logic                              up_ack_o,
  output logic                              up_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   up_dat_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   mem_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   mem_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] mem_bsel_o,
  input  logic                              mem_ack_i,
  input  logic                              mem_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   mem_dat_i,
  input  logic                              drain_i,
  output logic                              empty_o,
  output logic                              store_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_adr_o
);

  localparam int OW      = OPTION_OPERAND_WIDTH;
  localparam int BW      = bsel_width(OW);
  localparam int EW      = entry_width(OW);
  localparam int DAT_LSB = dat_lsb(OW);
  localparam int ADR_LSB = adr_lsb(OW);
  localparam logic [DEPTH_WIDTH:0] ONE_ENTRY = 1;

  state_e state;
  state_e next_state;

  logic                 store_ack;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DEPTH_WIDTH:0] fifo_count;
  logic [EW-1:0]        head;
  logic                 rd_active;
  logic                 wr_active;
  logic                 bus_done;

  assign rd_active = (state == RD_BUS);
  assign wr_active = (state == WR_BUS);
  assign bus_done  = wr_active && (mem_ack_i || mem_err_i);

  // The !store_ack term keeps a held request from being queued twice.
  assign push = up_req_i && up_we_i && !fifo_full && !drain_i &&
                !store_ack && !rd_active;
  assign pop  = bus_done;

  mor1kx_store_fifo #(
    .DEPTH_WIDTH (DEPTH_WIDTH),
    .DATA_WIDTH  (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({up_adr_i, up_dat_i, up_bsel_i}),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every output of this block gets its default before the case, so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!fifo_empty)
          next_state = WR_BUS;
        else if (up_req_i && !up_we_i && !drain_i)
          next_state = RD_BUS;
      end
      WR_BUS: begin
        if (bus_done && fifo_count == ONE_ENTRY && !push)
          next_state = IDLE;
      end
      RD_BUS: begin
        if (!up_req_i || up_we_i || mem_err_i)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      store_ack       <= 1'b0;
      store_err_o     <= 1'b0;
      store_err_adr_o <= '0;
    end else begin
      state       <= next_state;
      store_ack   <= push;
      store_err_o <= wr_active && mem_err_i;
      if (wr_active && mem_err_i)
        store_err_adr_o <= head[ADR_LSB +: OW];
    end
  end

  // Reads are a combinational pass-through; writes come from the FIFO head.
  assign mem_req_o  = wr_active || (rd_active && up_req_i && !up_we_i);
  assign mem_we_o   = wr_active;
  assign mem_adr_o  = rd_active ? up_adr_i : head[ADR_LSB +: OW];
  assign mem_dat_o  = head[DAT_LSB +: OW];
  assign mem_bsel_o = rd_active ? up_bsel_i : head[BW-1:0];

  assign up_ack_o = store_ack || (rd_active && mem_ack_i);
  assign up_err_o = rd_active && mem_err_i;
  assign up_dat_o = mem_dat_i;
  assign empty_o  = fifo_empty && !wr_active;

endmodule

// File: tb/tb_mor1kx_store_buffer.sv
// Directed bench for mor1kx_store_buffer: posting, full stall, ordering,
// refill pass-through, store errors, drain and mid-transfer reset.
module tb_mor1kx_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_req_i, up_we_i;
  logic [31:0] up_adr_i, up_dat_i;
  logic [3:0]  up_bsel_i;
  logic        up_ack_o, up_err_o;
  logic [31:0] up_dat_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_adr_o, mem_dat_o;
  logic [3:0]  mem_bsel_o;
  logic        mem_ack_i, mem_err_i;
  logic [31:0] mem_dat_i;
  logic        drain_i, empty_o, store_err_o;
  logic [31:0] store_err_adr_o;

  int total  = 0;
  int passed = 0;

  mor1kx_store_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .up_req_i        (up_req_i),
    .up_we_i         (up_we_i),
    .up_adr_i        (up_adr_i),
    .up_dat_i        (up_dat_i),
    .up_bsel_i       (up_bsel_i),
    .up_ack_o        (up_ack_o),
    .up_err_o        (up_err_o),
    .up_dat_o        (up_dat_o),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_adr_o       (mem_adr_o),
    .mem_dat_o       (mem_dat_o),
    .mem_bsel_o      (mem_bsel_o),
    .mem_ack_i       (mem_ack_i),
    .mem_err_i       (mem_err_i),
    .mem_dat_i       (mem_dat_i),
    .drain_i         (drain_i),
    .empty_o         (empty_o),
    .store_err_o     (store_err_o),
    .store_err_adr_o (store_err_adr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish before 200000");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a store and waits up to max_wait edges for its ack; req stays high.
  task automatic do_store(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] bsel, input int max_wait,
                          output int waited, output logic acked);
    up_req_i  = 1'b1;
    up_we_i   = 1'b1;
    up_adr_i  = adr;
    up_dat_i  = dat;
    up_bsel_i = bsel;
    waited    = 0;
    acked     = 1'b0;
    while (waited < max_wait && !acked) begin
      tick();
      waited++;
      acked = up_ack_o;
    end
  endtask

  task automatic wait_bus(input logic we, input string tag);
    int n = 0;
    while (!(mem_req_o === 1'b1 && mem_we_o === we) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_wait"}, 32'(n < 20), 32'd1);
  endtask

  // Waits for a bus write, checks it, and acks it for one cycle.
  task automatic bus_write(input logic [31:0] adr, input logic [31:0] dat, input string tag);
    wait_bus(1'b1, tag);
    check({tag, "_adr"}, mem_adr_o, adr);
    check({tag, "_dat"}, mem_dat_o, dat);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
  endtask

  initial begin
    int   w;
    logic a;
    logic saw_req;
    int   acks;
    logic [31:0] badr;

    rst = 1'b1;
    up_req_i = 0; up_we_i = 0; up_adr_i = 0; up_dat_i = 0; up_bsel_i = 0;
    mem_ack_i = 0; mem_err_i = 0; mem_dat_i = 0; drain_i = 0;
    tick();
    tick();
    check("rst_mem_req", mem_req_o, 0);
    check("rst_up_ack", up_ack_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_store_err", store_err_o, 0);
    check("rst_err_adr", store_err_adr_o, 0);
    rst = 1'b0;
    tick();

    // 1: single store
    do_store(32'h100, 32'hDEADBEEF, 4'hF, 5, w, a);
    check("t1_ack", a, 1);
    check("t1_ack_lat", w, 1);
    check("t1_req_not_yet", mem_req_o, 0);
    up_req_i = 0;
    tick();
    check("t1_mem_req", mem_req_o, 1);
    check("t1_mem_we", mem_we_o, 1);
    check("t1_ack_pulse", up_ack_o, 0);
    check("t1_bsel", mem_bsel_o, 4'hF);
    check("t1_busy", empty_o, 0);
    bus_write(32'h100, 32'hDEADBEEF, "t1_wr");
    check("t1_empty", empty_o, 1);

    // 2: fill with ack withheld, fifth stalls
    do_store(32'h0, 32'hA0, 4'hF, 5, w, a);
    check("t2_s0_lat", w, 1);
    for (int i = 1; i < 4; i++) begin
      do_store(32'(4 * i), 32'hA0 + 32'(i), 4'hF, 5, w, a);
      check("t2_s_lat", w, 2);
    end
    do_store(32'h10, 32'hA4, 4'hF, 6, w, a);
    check("t2_fifth_stall", a, 0);
    check("t2_head_adr", mem_adr_o, 32'h0);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    w = 1;
    while (!up_ack_o && w < 4) begin
      tick();
      w++;
    end
    check("t2_fifth_ack", up_ack_o, 1);
    check("t2_fifth_lat_le2", 32'(w <= 2), 1);
    up_req_i = 0;
    for (int i = 1; i < 5; i++)
      bus_write(32'(4 * i), 32'hA0 + 32'(i), "t2_order");
    check("t2_empty", empty_o, 1);

    // 3: read after write waits for the write
    do_store(32'h200, 32'h55, 4'hF, 5, w, a);
    check("t3_st_ack", a, 1);
    up_we_i = 1'b0;
    up_adr_i = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_still_write", mem_we_o, 1);
      check("t3_no_rd_ack", up_ack_o, 0);
    end
    bus_write(32'h200, 32'h55, "t3_wr");
    wait_bus(1'b0, "t3_rd");
    check("t3_rd_adr", mem_adr_o, 32'h200);
    check("t3_rd_noack", up_ack_o, 0);
    mem_dat_i = 32'h12345678;
    mem_ack_i = 1'b1;
    #1;
    check("t3_rd_ack", up_ack_o, 1);
    check("t3_rd_dat", up_dat_o, 32'h12345678);
    tick();
    mem_ack_i = 1'b0;
    up_req_i = 1'b0;
    tick();

    // 4: 8-beat wrapping refill burst
    up_req_i = 1'b1; up_we_i = 1'b0; up_adr_i = 32'h310; up_bsel_i = 4'hF;
    wait_bus(1'b0, "t4_start");
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      badr = 32'h300 | ((32'h10 + 32'(4 * i)) & 32'h1F);
      up_adr_i  = badr;
      mem_dat_i = 32'hB000_0000 + 32'(i);
      mem_ack_i = 1'b1;
      #1;
      check("t4_req", mem_req_o, 1);
      check("t4_we", mem_we_o, 0);
      check("t4_adr", mem_adr_o, badr);
      check("t4_dat", up_dat_o, 32'hB000_0000 + 32'(i));
      if (up_ack_o) acks++;
      tick();
      mem_ack_i = 1'b0;
    end
    check("t4_acks", acks, 8);
    up_req_i = 1'b0;
    tick();
    check("t4_req_drop", mem_req_o, 0);

    // 5: posted store error
    do_store(32'h400, 32'h44, 4'h3, 5, w, a);
    do_store(32'h404, 32'h45, 4'hC, 5, w, a);
    check("t5_second_ack", a, 1);
    up_req_i = 1'b0;
    wait_bus(1'b1, "t5_err");
    check("t5_err_adr_bus", mem_adr_o, 32'h400);
    check("t5_bsel", mem_bsel_o, 4'h3);
    mem_err_i = 1'b1;
    tick();
    mem_err_i = 1'b0;
    check("t5_err_pulse", store_err_o, 1);
    check("t5_err_adr", store_err_adr_o, 32'h400);
    check("t5_no_up_err", up_err_o, 0);
    tick();
    check("t5_err_once", store_err_o, 0);
    check("t5_err_adr_held", store_err_adr_o, 32'h400);
    bus_write(32'h404, 32'h45, "t5_next");
    check("t5_empty", empty_o, 1);

    // 6a: drain with three queued stores
    for (int i = 0; i < 3; i++)
      do_store(32'h500 + 32'(4 * i), 32'h60 + 32'(i), 4'hF, 5, w, a);
    drain_i = 1'b1;
    up_adr_i = 32'h50C;
    tick();
    check("t6_drain_noack0", up_ack_o, 0);
    for (int i = 0; i < 3; i++) begin
      bus_write(32'h500 + 32'(4 * i), 32'h60 + 32'(i), "t6_drain");
      check("t6_drain_noack", up_ack_o, 0);
      check("t6_empty_step", empty_o, 32'(i == 2));
    end
    tick();
    check("t6_drain_hold_noack", up_ack_o, 0);
    check("t6_drain_hold_empty", empty_o, 1);
    up_req_i = 1'b0;
    drain_i = 1'b0;
    tick();

    // 6b: reset in the middle of a bus write
    do_store(32'h600, 32'h70, 4'hF, 5, w, a);
    do_store(32'h604, 32'h71, 4'hF, 5, w, a);
    up_req_i = 1'b0;
    wait_bus(1'b1, "t6_rst");
    check("t6_rst_busy_adr", mem_adr_o, 32'h600);
    rst = 1'b1;
    tick();
    check("t6_rst_req", mem_req_o, 0);
    check("t6_rst_empty", empty_o, 1);
    check("t6_rst_err_adr", store_err_adr_o, 0);
    rst = 1'b0;
    saw_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw_req = saw_req | mem_req_o;
    end
    check("t6_no_stale", saw_req, 0);
    check("t6_final_empty", empty_o, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
